// File: rtl/axi_stream_insert_header_bytes_if.sv
// rtl/axi_stream_insert_header_bytes_if.sv - header, payload and output stream bundle for the header inserter
interface axi_stream_insert_header_bytes_if #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] data_in;
    logic [KEEP_WIDTH-1:0] keep_in;
    logic                  last_in;
    logic                  ready_in;
    logic                  valid_insert;
    logic [DATA_WIDTH-1:0] data_insert;
    logic [KEEP_WIDTH-1:0] keep_insert;
    logic                  ready_insert;
    logic                  valid_out;
    logic [DATA_WIDTH-1:0] data_out;
    logic [KEEP_WIDTH-1:0] keep_out;
    logic                  last_out;
    logic                  ready_out;

    modport master (
        output valid_in, data_in, keep_in, last_in,
        output valid_insert, data_insert, keep_insert, ready_out,
        input  ready_in, ready_insert, valid_out, data_out, keep_out, last_out
    );

    modport slave (
        input  valid_in, data_in, keep_in, last_in,
        input  valid_insert, data_insert, keep_insert, ready_out,
        output ready_in, ready_insert, valid_out, data_out, keep_out, last_out
    );
endinterface

// File: rtl/axi_stream_insert_header_bytes.sv
// rtl/axi_stream_insert_header_bytes.sv - prepends a 1..KEEP_WIDTH byte header to each payload packet
module axi_stream_insert_header_bytes #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input logic clk,
    input logic rst,
    axi_stream_insert_header_bytes_if.slave bus
);
    localparam int CW = $clog2(KEEP_WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, STREAM, TAIL} state_t;

    state_t                state, state_nxt;
    logic [DATA_WIDTH-1:0] residue;
    logic [CW-1:0]         h_cnt, tail_cnt, h_new, n_cnt;
    logic [CW:0]           sum;
    logic [CW+2:0]         sh_in, sh_res;
    logic                  slot_free, hdr_hs, pay_hs, load;
    logic [DATA_WIDTH-1:0] merged, data_nxt;
    logic [KEEP_WIDTH-1:0] keep_nxt;
    logic                  last_nxt;

    function automatic logic [KEEP_WIDTH-1:0] top_mask(input logic [CW:0] m);
        return ~({KEEP_WIDTH{1'b1}} >> m);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] byte_mask(input logic [KEEP_WIDTH-1:0] k);
        logic [DATA_WIDTH-1:0] r;
        for (int i = 0; i < KEEP_WIDTH; i++) r[i*8 +: 8] = {8{k[i]}};
        return r;
    endfunction

    always_comb begin
        h_new = '0;
        n_cnt = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            if (bus.keep_insert[i]) h_new = CW'(i + 1);
            if (bus.keep_in[i]) n_cnt = n_cnt + CW'(1);
        end
    end

    assign sum       = {1'b0, n_cnt} + {1'b0, h_cnt};
    assign sh_in     = {h_cnt, 3'b000};
    assign sh_res    = (CW+3)'(DATA_WIDTH) - sh_in;
    // Residue keeps the low h bytes of the previous word; they lead the next output word.
    assign merged    = (residue << sh_res) | (bus.data_in >> sh_in);
    assign slot_free = !bus.valid_out || bus.ready_out;
    assign hdr_hs    = bus.valid_insert && bus.ready_insert;
    assign pay_hs    = bus.valid_in && bus.ready_in;

    always_comb begin
        state_nxt        = state;
        bus.ready_in     = 1'b0;
        bus.ready_insert = 1'b0;
        load             = 1'b0;
        keep_nxt         = '0;
        last_nxt         = 1'b0;
        data_nxt         = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    bus.ready_insert = 1'b1;
                    if (bus.valid_insert) state_nxt = STREAM;
                end
                STREAM: begin
                    bus.ready_in = slot_free;
                    if (bus.valid_in && slot_free) begin
                        load     = 1'b1;
                        keep_nxt = {KEEP_WIDTH{1'b1}};
                        if (bus.last_in) begin
                            if (sum <= (CW+1)'(KEEP_WIDTH)) begin
                                keep_nxt  = top_mask(sum);
                                last_nxt  = 1'b1;
                                state_nxt = IDLE;
                            end else begin
                                state_nxt = TAIL;
                            end
                        end
                        data_nxt = merged & byte_mask(keep_nxt);
                    end
                end
                TAIL: begin
                    if (slot_free) begin
                        load      = 1'b1;
                        keep_nxt  = top_mask({1'b0, tail_cnt});
                        last_nxt  = 1'b1;
                        data_nxt  = (residue << sh_res) & byte_mask(keep_nxt);
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            residue       <= '0;
            h_cnt         <= '0;
            tail_cnt      <= '0;
            bus.valid_out <= 1'b0;
            bus.data_out  <= '0;
            bus.keep_out  <= '0;
            bus.last_out  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (hdr_hs) begin
                residue <= bus.data_insert;
                h_cnt   <= h_new;
            end
            if (pay_hs) begin
                residue  <= bus.data_in;
                tail_cnt <= CW'(sum - (CW+1)'(KEEP_WIDTH));
            end
            if (load) begin
                bus.valid_out <= 1'b1;
                bus.data_out  <= data_nxt;
                bus.keep_out  <= keep_nxt;
                bus.last_out  <= last_nxt;
            end else if (bus.ready_out) begin
                bus.valid_out <= 1'b0;
            end
        end
    end
endmodule
